// File: rtl/sdrd_pkg.sv
// sdrd_pkg
// Shared definitions for the serial-status PLD window sequencer:
//   - seq_state_e : sequencer state encoding
//   - SHIFT_CODE_DEFAULT : BA7..BA4 code used on shift strobes
//   - P_HOST / P_POLL : requester port indices
package sdrd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_GAP    = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_e;

    localparam logic [3:0] SHIFT_CODE_DEFAULT = 4'h0;

    localparam int P_HOST = 0;
    localparam int P_POLL = 1;

endpackage

// File: rtl/sdrd_seq_arbiter_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. The pick is combinational from req and
// the last-grant register; the caller registers it. The last-grant register
// loads the port index presented on upd_port while update is high.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req[1:0]   : per-port requests
//   update     : load last-grant register (asserted in DONE)
//   upd_port   : index of the port that held the grant
//   pick[1:0]  : one-hot winner for the current req pattern (00 if none)
module rr_arb2
    import sdrd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_port,
    output logic [1:0] pick
);

    logic       last_r;
    logic [1:0] pick_s;

    // Track the most recently granted port; resets to the poller so the host wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= 1'(P_POLL);
        end else if (update) begin
            last_r <= upd_port;
        end else begin
            last_r <= last_r;
        end
    end

    // Choose the winner; on a tie the port not granted last wins
    always_comb begin
        pick_s = 2'b00;
        if (req == 2'b11) begin
            if (last_r == 1'(P_POLL)) begin
                pick_s = 2'b01;
            end else begin
                pick_s = 2'b10;
            end
        end else if (req[P_HOST]) begin
            pick_s = 2'b01;
        end else if (req[P_POLL]) begin
            pick_s = 2'b10;
        end else begin
            pick_s = 2'b00;
        end
    end

    assign pick = pick_s;

endmodule

// File: rtl/sdrd_seq_arbiter.sv
// sdrd_seq_arbiter
// Shares the serial-status PLD window between a host (port 0) and a poller
// (port 1). Each granted transaction issues one configuration strobe with the
// winner's BA7..BA4 code, then BITS shift strobes, shifting SDRD in MSB first.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req[1:0]        : per-port request, held until done
//   sel0, sel1      : per-port configuration code, sampled at grant
//   gnt[1:0]        : one-hot grant, ARB through DONE
//   done            : one-cycle pulse, rdata valid from that cycle
//   rdata[BITS-1:0] : assembled word, held until the next done
//   win_en          : window qualifier
//   ba_sel[3:0]     : BA7..BA4 code
//   strobe          : write-clock strobe to the PLD
//   sdrd            : serial data from the PLD (already synchronised)
//   busy            : high outside IDLE
module sdrd_seq_arbiter
    import sdrd_pkg::*;
#(
    parameter int         BITS       = 8,
    parameter int         STROBE_CYC = 2,
    parameter int         GAP_CYC    = 1,
    parameter logic [3:0] SHIFT_CODE = SHIFT_CODE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [3:0]      sel0,
    input  logic [3:0]      sel1,
    output logic [1:0]      gnt,
    output logic            done,
    output logic [BITS-1:0] rdata,
    output logic            win_en,
    output logic [3:0]      ba_sel,
    output logic            strobe,
    input  logic            sdrd,
    output logic            busy
);

    localparam int SW   = $clog2(BITS + 1);
    localparam int PMAX = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
    localparam int PW   = $clog2(PMAX + 1);

    seq_state_e      state_r;
    logic [SW-1:0]   slot_r;
    logic [PW-1:0]   phase_r;
    logic [BITS-1:0] shift_r;
    logic [BITS-1:0] shift_nxt_s;
    logic [3:0]      sel_r;
    logic [1:0]      gnt_r;
    logic            done_r;
    logic [BITS-1:0] rdata_r;
    logic            win_en_r;
    logic [3:0]      ba_sel_r;
    logic            strobe_r;
    logic            busy_r;
    logic [1:0]      pick_s;
    logic            arb_upd_s;

    assign arb_upd_s = (state_r == ST_DONE);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .update   (arb_upd_s),
        .upd_port (gnt_r[P_POLL]),
        .pick     (pick_s)
    );

    // Next shift-register value: earlier bits move up, sdrd enters the LSB
    always_comb begin
        shift_nxt_s    = shift_r << 1;
        shift_nxt_s[0] = sdrd;
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            slot_r   <= '0;
            phase_r  <= '0;
            shift_r  <= '0;
            sel_r    <= 4'h0;
            gnt_r    <= 2'b00;
            done_r   <= 1'b0;
            rdata_r  <= '0;
            win_en_r <= 1'b0;
            ba_sel_r <= 4'h0;
            strobe_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        // Grant is decided on the edge into ARB so gnt is visible during ARB
                        state_r <= ST_ARB;
                        gnt_r   <= pick_s;
                        sel_r   <= pick_s[P_POLL] ? sel1 : sel0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARB: begin
                    state_r  <= ST_SETUP;
                    slot_r   <= '0;
                    shift_r  <= '0;
                    win_en_r <= 1'b1;
                    ba_sel_r <= sel_r;
                end
                ST_SETUP: begin
                    state_r  <= ST_STROBE;
                    strobe_r <= 1'b1;
                    phase_r  <= PW'(1);
                end
                ST_STROBE: begin
                    if (phase_r == PW'(STROBE_CYC)) begin
                        state_r  <= ST_SAMPLE;
                        strobe_r <= 1'b0;
                    end else begin
                        phase_r <= phase_r + PW'(1);
                    end
                end
                ST_SAMPLE: begin
                    // The configuration slot's read-back is discarded
                    if (slot_r != '0) begin
                        shift_r <= shift_nxt_s;
                    end else begin
                        shift_r <= shift_r;
                    end
                    state_r  <= ST_GAP;
                    win_en_r <= 1'b0;
                    ba_sel_r <= 4'h0;
                    phase_r  <= PW'(1);
                end
                ST_GAP: begin
                    if (phase_r == PW'(GAP_CYC)) begin
                        if (slot_r == SW'(BITS)) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            rdata_r <= shift_r;
                        end else begin
                            state_r  <= ST_SETUP;
                            slot_r   <= slot_r + SW'(1);
                            win_en_r <= 1'b1;
                            ba_sel_r <= SHIFT_CODE;
                        end
                    end else begin
                        phase_r <= phase_r + PW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 2'b00;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    gnt_r    <= 2'b00;
                    win_en_r <= 1'b0;
                    ba_sel_r <= 4'h0;
                    strobe_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt    = gnt_r;
    assign done   = done_r;
    assign rdata  = rdata_r;
    assign win_en = win_en_r;
    assign ba_sel = ba_sel_r;
    assign strobe = strobe_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_sdrd_seq_arbiter.sv
// tb_sdrd_seq_arbiter
// Directed bench: default-parameter instance for host read, round-robin,
// request withdrawal and mid-transaction reset; a BITS=1/STROBE_CYC=1/GAP_CYC=1
// instance for the short-slot sweep.
module tb_sdrd_seq_arbiter;

    logic       clk;
    logic       rst;

    logic [1:0] req;
    logic [3:0] sel0;
    logic [3:0] sel1;
    logic [1:0] gnt;
    logic       done;
    logic [7:0] rdata;
    logic       win_en;
    logic [3:0] ba_sel;
    logic       strobe;
    logic       sdrd;
    logic       busy;

    logic [1:0] req_s;
    logic [3:0] sel0_s;
    logic [3:0] sel1_s;
    logic [1:0] gnt_s;
    logic       done_s;
    logic [0:0] rdata_s;
    logic       win_en_s;
    logic [3:0] ba_sel_s;
    logic       strobe_s;
    logic       sdrd_s;
    logic       busy_s;

    int err_cnt = 0;
    int chk_cnt = 0;

    sdrd_seq_arbiter u_dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .sel0   (sel0),
        .sel1   (sel1),
        .gnt    (gnt),
        .done   (done),
        .rdata  (rdata),
        .win_en (win_en),
        .ba_sel (ba_sel),
        .strobe (strobe),
        .sdrd   (sdrd),
        .busy   (busy)
    );

    sdrd_seq_arbiter #(.BITS(1), .STROBE_CYC(1), .GAP_CYC(1)) u_small (
        .clk    (clk),
        .rst    (rst),
        .req    (req_s),
        .sel0   (sel0_s),
        .sel1   (sel1_s),
        .gnt    (gnt_s),
        .done   (done_s),
        .rdata  (rdata_s),
        .win_en (win_en_s),
        .ba_sel (ba_sel_s),
        .strobe (strobe_s),
        .sdrd   (sdrd_s),
        .busy   (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One default-parameter transaction; edge 1 is the first edge with req seen in IDLE.
    task automatic run_main(input string tag, input logic [1:0] exp_gnt,
                            input logic [3:0] exp_sel, input logic [7:0] pat, input int drop_at);
        int   done_cyc = 0;
        int   dones = 0;
        int   rises = 0;
        int   hi = 0;
        int   cfg = 0;
        int   win = 0;
        int   gbad = 0;
        int   bbad = 0;
        logic prev_strobe = 1'b0;
        for (int c = 1; c <= 47; c++) begin
            if (c >= 3) begin
                int k;
                k = (c - 3) / 5;
                if (k == 0) sdrd = 1'b1;
                else        sdrd = pat[8 - k];
            end else begin
                sdrd = 1'b0;
            end
            if (c == drop_at) req = 2'b00;
            step();
            if (done) begin
                dones++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (strobe && !prev_strobe) rises++;
            if (strobe) hi++;
            prev_strobe = strobe;
            if (win_en) win++;
            if (win_en && ba_sel == exp_sel) cfg++;
            if (gnt !== exp_gnt) gbad++;
            if (busy !== 1'b1) bbad++;
        end
        chk({tag, "_done_cycle"}, done_cyc, 47);
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_rdata"}, rdata, pat);
        chk({tag, "_strobe_count"}, rises, 9);
        chk({tag, "_strobe_high"}, hi, 18);
        chk({tag, "_win_cycles"}, win, 36);
        chk({tag, "_cfg_sel_cycles"}, cfg, 4);
        chk({tag, "_gnt_bad"}, gbad, 0);
        chk({tag, "_busy_bad"}, bbad, 0);
        step();
        chk({tag, "_idle_done"}, done, 1'b0);
        chk({tag, "_idle_gnt"}, gnt, 2'b00);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_rdata_held"}, rdata, pat);
    endtask

    // Short-slot instance: L=4, done expected on edge 10.
    task automatic run_small(input string tag, input logic exp_bit);
        int   done_cyc = 0;
        int   rises = 0;
        int   win = 0;
        int   gbad = 0;
        logic prev_strobe = 1'b0;
        req_s = 2'b01;
        for (int c = 1; c <= 10; c++) begin
            // configuration slot samples on edge 5, the shift slot on edge 9
            sdrd_s = (c <= 6) ? 1'b1 : exp_bit;
            step();
            if (done_s && done_cyc == 0) done_cyc = c;
            if (strobe_s && !prev_strobe) rises++;
            prev_strobe = strobe_s;
            if (win_en_s) win++;
            if (gnt_s !== 2'b01 || busy_s !== 1'b1) gbad++;
        end
        req_s = 2'b00;
        chk({tag, "_done_cycle"}, done_cyc, 10);
        chk({tag, "_rdata"}, rdata_s, exp_bit);
        chk({tag, "_strobes"}, rises, 2);
        chk({tag, "_win_cycles"}, win, 6);
        chk({tag, "_gnt_busy_bad"}, gbad, 0);
        step();
        chk({tag, "_idle_busy"}, busy_s, 1'b0);
        chk({tag, "_idle_ba_sel"}, ba_sel_s, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        req    = 2'b00;
        sel0   = 4'hA;
        sel1   = 4'h5;
        sdrd   = 1'b0;
        req_s  = 2'b00;
        sel0_s = 4'h3;
        sel1_s = 4'h6;
        sdrd_s = 1'b0;
        step();
        step();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_win_en", win_en, 1'b0);
        chk("rst_ba_sel", ba_sel, 4'h0);
        chk("rst_strobe", strobe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_small_busy", busy_s, 1'b0);
        rst = 1'b0;
        step();

        // Single host read
        req = 2'b01;
        run_main("host", 2'b01, 4'hA, 8'hB2, 0);
        req = 2'b00;
        step();

        // Round-robin after a fresh reset: host first, then alternate
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        req = 2'b11;
        run_main("rr0", 2'b01, 4'hA, 8'h3C, 0);
        run_main("rr1", 2'b10, 4'h5, 8'hE1, 0);
        run_main("rr2", 2'b01, 4'hA, 8'h0F, 0);
        run_main("rr3", 2'b10, 4'h5, 8'h96, 0);
        req = 2'b00;
        step();

        // Host withdraws in slot 3; transaction still completes
        req = 2'b01;
        run_main("wd", 2'b01, 4'hA, 8'h5C, 18);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wd_no_regrant", {busy, gnt}, 3'b000);
        end

        // Reset during the STROBE of slot 5 (edge 28)
        req  = 2'b01;
        sdrd = 1'b1;
        for (int i = 0; i < 28; i++) step();
        chk("mr_pre_strobe", strobe, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_strobe", strobe, 1'b0);
        chk("mr_win_en", win_en, 1'b0);
        chk("mr_gnt", gnt, 2'b00);
        chk("mr_busy", busy, 1'b0);
        chk("mr_rdata", rdata, 8'h00);
        chk("mr_ba_sel", ba_sel, 4'h0);
        #1;
        rst = 1'b0;
        run_main("post", 2'b01, 4'hA, 8'h69, 0);
        req = 2'b00;
        step();

        // Short-slot instance
        run_small("sw1", 1'b1);
        run_small("sw0", 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sdrd_seq_arbiter.md
# sdrd_seq_arbiter

Sequencer and two-port arbiter for the serial-status PLD window (BA13=0, BA12=1, ~SSER, BR_W=1). It shares the window between a host requester (port 0) and a background poller (port 1). For each granted transaction it drives one configuration strobe carrying the requester's BA7..BA4 code, then BITS shift strobes, and assembles the SDRD bits into a parallel word. It sits between the bus-decode logic and the PLD and owns all window strobes while a transaction is active.

## Interface
- BITS, 8: serial bits shifted per transaction; legal range 1–16.
- STROBE_CYC, 2: cycles that strobe is held high per slot; must be ≥1.
- GAP_CYC, 1: idle cycles after each slot with win_en low; must be ≥1.
- SHIFT_CODE, 4'h0: BA7..BA4 code driven on shift strobes.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  per-port request; must be held until that port's done.
- sel0  in  4  port 0 BA7..BA4 configuration code; sampled at grant.
- sel1  in  4  port 1 BA7..BA4 configuration code; sampled at grant.
- gnt  out  2  one-hot grant, held from ARB through DONE.
- done  out  1  one-cycle pulse in DONE; rdata valid from that cycle.
- rdata  out  BITS  assembled word, MSB first; holds until the next done.
- win_en  out  1  qualifies the window (drives BA12=1, BA13=0, SSER=0, BR_W=1).
- ba_sel  out  4  BA7..BA4 code.
- strobe  out  1  write-clock strobe to the PLD.
- sdrd  in  1  serial data from the PLD; externally synchronised.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ARB, SETUP, STROBE, SAMPLE, GAP, DONE.
- IDLE: if any req bit is high, go to ARB. rdata is held.
- ARB (1 cycle): pick the winner, latch its sel, assert gnt, clear slot_cnt and the shift register.
  - Round-robin: if both ports request, grant the port that was not granted last.
  - The last-granted pointer resets to port 1, so port 0 wins the first simultaneous contest.
- Slots: slot 0 is the configuration slot (ba_sel = latched sel). Slots 1..BITS are shift slots (ba_sel = SHIFT_CODE).
- Each slot runs SETUP (1 cycle) → STROBE (STROBE_CYC cycles) → SAMPLE (1 cycle) → GAP (GAP_CYC cycles).
  - SETUP: win_en=1, ba_sel valid, strobe=0.
  - STROBE: strobe=1, win_en=1, ba_sel stable.
  - SAMPLE: strobe=0, win_en=1. In shift slots, sdrd is shifted into the LSB and earlier bits move up. The configuration slot's sample is discarded.
  - GAP: win_en=0, ba_sel=0, strobe=0.
- After the GAP of slot BITS, go to DONE. Otherwise increment slot_cnt and return to SETUP.
- DONE (1 cycle): rdata is loaded from the shift register, done=1, gnt stays high. Next state is IDLE; the pointer updates here.
- Dropping req mid-transaction does not abort: the transaction completes and done still pulses.
- req changes on ports not granted are ignored until the next ARB.
- Reset, at any time including mid-slot: state goes to IDLE and all outputs go to 0 immediately (gnt, done, rdata, win_en, ba_sel, strobe, busy). The pointer and counters are cleared. No partial rdata is published.

## Timing
- Slot length L = 2 + STROBE_CYC + GAP_CYC (default 5).
- Request-to-done latency, counted from the first clock edge with req high in IDLE: 1 (ARB) + (BITS+1)·L + 1. The default is 47 edges, with done in cycle 47.
- Back-to-back operation: IDLE lasts at least 1 cycle between transactions, so the minimum period is latency + 1.
- sdrd is sampled at the rising edge that ends SAMPLE. The PLD therefore has 1 cycle after strobe falls to settle.
- win_en, ba_sel and strobe are registered outputs with no combinational path from req or sdrd.

## Structure
- Shared package `sdrd_pkg` holds:
  - the state enum;
  - SHIFT_CODE default;
  - port index constants P_HOST=0 and P_POLL=1.
- One sub-module, `rr_arb2`: two-request round-robin arbiter with a last-grant register and an update strobe (asserted in DONE).
- Sequencer FSM, slot counter, phase counter and shift register live in the top level.

## Test plan
- Single host read: req=2'b01, sel0=4'hA, sdrd pattern 1,0,1,1,0,0,1,0 over the shift slots → ba_sel=A in slot 0 only, 9 strobes each 2 cycles high, done at cycle 47, rdata=8'hB2, gnt=01 throughout.
- Simultaneous requests after reset: req=2'b11 → gnt=01 first. Then gnt=10 after ≥1 IDLE cycle, with ba_sel=sel1 in that configuration slot.
- Fairness: port 0 re-requests immediately after each done while port 1 holds req → grants alternate 01,10,01,10 over four transactions.
- Req withdrawal: port 0 drops req in slot 3 → transaction completes, done pulses at cycle 47, no new grant afterwards.
- Mid-transaction reset: rst pulsed during a STROBE of slot 5 → strobe, win_en, gnt and busy drop asynchronously and rdata=0. After release with req=01, a full 47-cycle transaction runs.
- Parameter sweep: BITS=1 with STROBE_CYC=1, GAP_CYC=1 → L=4, done at cycle 10, rdata equals the single sdrd sample.
